pc_predict_unit: RTL and testbench

PC_PREDICT_UNIT -- requirements
Module: pc_predict_unit

---
 rtl/pc_predict_unit_pkg.sv | 23 ++
 rtl/pc_btb.sv | 84 ++++++++
 rtl/pc_predict_unit.sv | 100 ++++++++++
 tb/tb_pc_predict_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pc_predict_unit_pkg.sv
// Shared definitions for the fetch PC predictor: counter encodings, width
// default and the sequential fetch increment.
package pc_predict_unit_pkg;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    localparam int XLEN_DEFAULT = 32;
    localparam int PC_INC       = 4;

    // Two-bit saturating counter step toward the resolved direction.
    function automatic ctr_e ctr_update(input ctr_e cur, input logic taken);
        if (taken) begin
            return (cur == ST) ? ST : ctr_e'(cur + 2'd1);
        end
        return (cur == SNT) ? SNT : ctr_e'(cur - 2'd1);
    endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// single-port update from the execute-stage resolution.
module pc_btb
    import pc_predict_unit_pkg::*;
#(
    parameter int XLEN        = XLEN_DEFAULT,
    parameter int BTB_ENTRIES = 16
) (
    input  logic            iClk,
    input  logic            iRst,
    input  logic [XLEN-1:0] iLookupPc,
    output logic            oTaken,
    output logic [XLEN-1:0] oTarget,
    input  logic            iUpdValid,
    input  logic            iUpdTaken,
    input  logic [XLEN-1:0] iUpdPc,
    input  logic [XLEN-1:0] iUpdTarget
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic             valid_q [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_q   [BTB_ENTRIES];
    logic [XLEN-1:0]  tgt_q   [BTB_ENTRIES];
    ctr_e             ctr_q   [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;
    logic             wr_en;
    ctr_e             ctr_d;
    logic [XLEN-1:0]  tgt_d;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^{iLookupPc[1:0], iUpdPc[1:0]};

    assign lk_idx  = iLookupPc[IDX_W+1:2];
    assign lk_tag  = iLookupPc[XLEN-1:IDX_W+2];
    assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign oTaken  = lk_hit && (ctr_q[lk_idx] >= WT);
    assign oTarget = tgt_q[lk_idx];

    assign up_idx = iUpdPc[IDX_W+1:2];
    assign up_tag = iUpdPc[XLEN-1:IDX_W+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Not-taken misses never allocate; taken misses start weakly taken.
    always_comb begin
        wr_en = 1'b0;
        ctr_d = ctr_q[up_idx];
        tgt_d = iUpdTaken ? iUpdTarget : tgt_q[up_idx];
        if (iUpdValid) begin
            if (up_hit) begin
                wr_en = 1'b1;
                ctr_d = ctr_update(ctr_q[up_idx], iUpdTaken);
            end else if (iUpdTaken) begin
                wr_en = 1'b1;
                ctr_d = WT;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= SNT;
            end
        end else if (wr_en) begin
            valid_q[up_idx] <= 1'b1;
            ctr_q[up_idx]   <= ctr_d;
        end
    end

    // Tag and target are qualified by the valid bit, so they need no reset.
    always_ff @(posedge iClk) begin
        if (wr_en) begin
            tag_q[up_idx] <= up_tag;
            tgt_q[up_idx] <= tgt_d;
        end
    end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch PC register with BTB-driven next-PC prediction, execute-stage
// redirect on mispredict, and a saturating mispredict counter.
module pc_predict_unit
    import pc_predict_unit_pkg::*;
#(
    parameter int              XLEN        = XLEN_DEFAULT,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic            iClk,
    input  logic            iRst,
    input  logic            iStall,
    input  logic            iResValid,
    input  logic [XLEN-1:0] iResPc,
    input  logic [XLEN-1:0] iResPredPc,
    input  logic [XLEN-1:0] iOffset,
    input  logic [XLEN-1:0] iRs1,
    input  logic            iBranch,
    input  logic            iJump,
    input  logic            iPcSrc,
    input  logic            iZero,
    output logic [XLEN-1:0] oPc,
    output logic [XLEN-1:0] oPredPc,
    output logic            oPredTaken,
    output logic            oFlush,
    output logic [15:0]     oMispredCnt
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(PC_INC);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            flush_q, flush_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [XLEN-1:0] actual_pc, jalr_sum, btb_target;
    logic            res_taken, mispred, btb_taken;

    assign jalr_sum  = iRs1 + iOffset;
    assign res_taken = iJump || (iBranch && iZero);

    always_comb begin
        actual_pc = iResPc + PC_STEP;
        if (iJump && iPcSrc) begin
            actual_pc = {jalr_sum[XLEN-1:1], 1'b0};
        end else if (res_taken) begin
            actual_pc = iResPc + iOffset;
        end
    end

    assign mispred = iResValid && (actual_pc != iResPredPc);

    pc_btb #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .iClk       (iClk),
        .iRst       (iRst),
        .iLookupPc  (pc_q),
        .oTaken     (btb_taken),
        .oTarget    (btb_target),
        .iUpdValid  (iResValid && (iBranch || iJump)),
        .iUpdTaken  (res_taken),
        .iUpdPc     (iResPc),
        .iUpdTarget (actual_pc)
    );

    assign oPredTaken = btb_taken;
    assign oPredPc    = btb_taken ? btb_target : (pc_q + PC_STEP);

    // Redirect outranks stall so a resolved mispredict is never lost.
    always_comb begin
        pc_d    = oPredPc;
        flush_d = mispred;
        cnt_d   = cnt_q;
        if (mispred) begin
            pc_d = actual_pc;
        end else if (iStall) begin
            pc_d = pc_q;
        end
        if (mispred && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            pc_q    <= pc_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
        end
    end

    assign oPc         = pc_q;
    assign oFlush      = flush_q;
    assign oMispredCnt = cnt_q;

endmodule

// File: tb/tb_pc_predict_unit.sv
// Scoreboard bench for pc_predict_unit: directed resolutions push expected
// fetch state, a negedge monitor pops and compares.
module tb_pc_predict_unit;

    logic        iClk = 1'b0;
    logic        iRst, iStall, iResValid;
    logic [31:0] iResPc, iResPredPc, iOffset, iRs1;
    logic        iBranch, iJump, iPcSrc, iZero;
    logic [31:0] oPc, oPredPc;
    logic        oPredTaken, oFlush;
    logic [15:0] oMispredCnt;

    pc_predict_unit dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iStall      (iStall),
        .iResValid   (iResValid),
        .iResPc      (iResPc),
        .iResPredPc  (iResPredPc),
        .iOffset     (iOffset),
        .iRs1        (iRs1),
        .iBranch     (iBranch),
        .iJump       (iJump),
        .iPcSrc      (iPcSrc),
        .iZero       (iZero),
        .oPc         (oPc),
        .oPredPc     (oPredPc),
        .oPredTaken  (oPredTaken),
        .oFlush      (oFlush),
        .oMispredCnt (oMispredCnt)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        int          cyc;
        string       name;
        logic [31:0] pc;
        logic        flush;
        logic [15:0] cnt;
        logic [31:0] pred;
        logic        taken;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    always @(negedge iClk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc != cyc) begin
                total++;
                bad++;
                $display("FAIL %s: stale entry for cycle %0d seen at %0d", e.name, e.cyc, cyc);
            end else begin
                cmp({e.name, ".pc"},    oPc,                 e.pc);
                cmp({e.name, ".flush"}, {31'd0, oFlush},     {31'd0, e.flush});
                cmp({e.name, ".cnt"},   {16'd0, oMispredCnt}, {16'd0, e.cnt});
                cmp({e.name, ".pred"},  oPredPc,             e.pred);
                cmp({e.name, ".taken"}, {31'd0, oPredTaken}, {31'd0, e.taken});
            end
        end
    end

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic expect_st(input string nm, input logic [31:0] pc, input logic fl,
                             input logic [15:0] cnt, input logic [31:0] pred, input logic tk);
        exp_t x;
        x.cyc = cyc; x.name = nm; x.pc = pc; x.flush = fl;
        x.cnt = cnt; x.pred = pred; x.taken = tk;
        q.push_back(x);
    endtask

    task automatic clr_res();
        iResValid = 1'b0; iBranch = 1'b0; iJump = 1'b0; iPcSrc = 1'b0; iZero = 1'b0;
        iResPc = '0; iResPredPc = '0; iOffset = '0; iRs1 = '0;
    endtask

    task automatic drive_res(input logic b, input logic j, input logic s, input logic z,
                             input logic [31:0] rpc, input logic [31:0] ppc,
                             input logic [31:0] off, input logic [31:0] rs1);
        iResValid = 1'b1; iBranch = b; iJump = j; iPcSrc = s; iZero = z;
        iResPc = rpc; iResPredPc = ppc; iOffset = off; iRs1 = rs1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        iRst = 1'b1; iStall = 1'b0;
        clr_res();
        step(); step();
        expect_st("rst", 32'h0, 1'b0, 16'd0, 32'h4, 1'b0);
        iRst = 1'b0;
        step(); expect_st("seq4", 32'h4, 1'b0, 16'd0, 32'h8,  1'b0);
        step(); expect_st("seq8", 32'h8, 1'b0, 16'd0, 32'hC,  1'b0);
        step(); expect_st("seqC", 32'hC, 1'b0, 16'd0, 32'h10, 1'b0);

        // taken branch at 0x10 predicted fall-through
        drive_res(1, 0, 0, 1, 32'h10, 32'h14, 32'h40, 32'h0);
        step(); expect_st("br_redir", 32'h50, 1'b1, 16'd1, 32'h54, 1'b0);
        clr_res();
        step(); expect_st("br_after", 32'h54, 1'b0, 16'd1, 32'h58, 1'b0);
        // non-branch mispredict steers fetch back to 0x10
        drive_res(0, 0, 0, 0, 32'hC, 32'h20, 32'h0, 32'h0);
        step(); expect_st("to_0x10", 32'h10, 1'b1, 16'd2, 32'h50, 1'b1);
        clr_res();
        step(); expect_st("follow_pred", 32'h50, 1'b0, 16'd2, 32'h54, 1'b0);

        // JALR correctly predicted: target bit0 cleared
        drive_res(0, 1, 1, 0, 32'h20, 32'h1006, 32'h4, 32'h1003);
        step(); expect_st("jalr_ok", 32'h54, 1'b0, 16'd2, 32'h58, 1'b0);

        drive_res(0, 0, 0, 0, 32'h2C, 32'h0, 32'h0, 32'h0);
        step(); expect_st("to_0x30", 32'h30, 1'b1, 16'd3, 32'h34, 1'b0);
        clr_res();

        // hold fetch at 0x30 while training its counter
        iStall = 1'b1;
        drive_res(1, 0, 0, 1, 32'h30, 32'h130, 32'h100, 32'h0);
        step(); expect_st("ctr2",  32'h30, 1'b0, 16'd3, 32'h130, 1'b1);
        step(); expect_st("ctr3",  32'h30, 1'b0, 16'd3, 32'h130, 1'b1);
        step(); expect_st("ctr3s", 32'h30, 1'b0, 16'd3, 32'h130, 1'b1);
        drive_res(1, 0, 0, 0, 32'h30, 32'h34, 32'h100, 32'h0);
        step(); expect_st("ctr2n", 32'h30, 1'b0, 16'd3, 32'h130, 1'b1);
        step(); expect_st("ctr1",  32'h30, 1'b0, 16'd3, 32'h34,  1'b0);
        step(); expect_st("ctr0",  32'h30, 1'b0, 16'd3, 32'h34,  1'b0);

        // redirect wins over stall
        drive_res(0, 0, 0, 0, 32'h7C, 32'h0, 32'h0, 32'h0);
        step(); expect_st("stall_redir", 32'h80, 1'b1, 16'd4, 32'h84, 1'b0);
        iStall = 1'b0;
        clr_res();
        step(); expect_st("unstall", 32'h84, 1'b0, 16'd4, 32'h88, 1'b0);

        drive_res(0, 0, 0, 0, 32'h1C, 32'h0, 32'h0, 32'h0);
        step(); expect_st("to_0x20", 32'h20, 1'b1, 16'd5, 32'h1006, 1'b1);
        clr_res();
        step(); expect_st("jalr_follow", 32'h1006, 1'b0, 16'd5, 32'h100A, 1'b0);

        // wrap at top of address space
        drive_res(0, 0, 0, 0, 32'hFFFF_FFF8, 32'h0, 32'h0, 32'h0);
        step(); expect_st("to_top", 32'hFFFF_FFFC, 1'b1, 16'd6, 32'h0, 1'b0);
        clr_res();
        step(); expect_st("wrap", 32'h0, 1'b0, 16'd6, 32'h4, 1'b0);

        // reset concurrent with a mispredict
        iRst = 1'b1;
        drive_res(0, 0, 0, 0, 32'h100, 32'h0, 32'h0, 32'h0);
        step(); expect_st("rst_redir", 32'h0, 1'b0, 16'd0, 32'h4, 1'b0);
        iRst = 1'b0;
        clr_res();
        step(); expect_st("post4", 32'h4,  1'b0, 16'd0, 32'h8,  1'b0);
        step(); expect_st("post8", 32'h8,  1'b0, 16'd0, 32'hC,  1'b0);
        step(); expect_st("postC", 32'hC,  1'b0, 16'd0, 32'h10, 1'b0);
        step(); expect_st("btb_cleared", 32'h10, 1'b0, 16'd0, 32'h14, 1'b0);

        // JAL uses iResPc, not iRs1
        drive_res(0, 1, 0, 0, 32'h40, 32'h44, 32'h20, 32'h999);
        step(); expect_st("jal", 32'h60, 1'b1, 16'd1, 32'h64, 1'b0);
        clr_res();
        step(); expect_st("jal_after", 32'h64, 1'b0, 16'd1, 32'h68, 1'b0);

        @(negedge iClk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
